ob_cn_queue: RTL and testbench
==============================

OB_CN_QUEUE -- requirements
Module: ob_cn_queue

Interface
REQ-001 Parameter N, default 8, number of conditional entries (N >= 2).
REQ-002 Parameter W_OCC, default $clog2(N+1), occupancy count width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 alloc_vld  input  1  new conditional command offered.
REQ-006 alloc_cmd  input  ob_pkg::cmd_t  offered command: uid, cn_cond, trigger price, payload.
REQ-007 alloc_rdy  output  1  free slot exists; alloc accepted when alloc_vld & alloc_rdy.
REQ-008 cntrl_evt_texe_r  input  1  trade-execution event; conditions are evaluated on it.
REQ-009 lm_bid_table_vld_r / lm_bid_table_r  input  1 / ob_pkg::table_t  best bid.
REQ-010 lm_ask_table_vld_r / lm_ask_table_r  input  1 / ob_pkg::table_t  best ask.
REQ-011 mtr_vld_r  output  1  matured command valid (registered).
REQ-012 mtr_r  output  ob_pkg::cmd_t  matured command (registered).
REQ-013 mtr_accept  input  1  consumer takes mtr_r.
REQ-014 cancel_vld / cancel_uid  input  1 / ob_pkg::uid_t  cancel request (CANCEL_EN only).
REQ-015 cancel_hit_r  output  1  one-cycle pulse: cancel removed an entry (CANCEL_EN only).
REQ-016 occ_r  output  W_OCC  number of busy entries; full_r  output  1  occ_r == N.

Function
REQ-017 alloc_rdy SHALL equal ~full_r; an accepted command SHALL occupy the lowest-index free entry, which becomes busy the next cycle.
REQ-018 A slot freed in cycle t SHALL NOT be allocated before cycle t+1.
REQ-019 Each entry SHALL record its age relative to all others (N x N age matrix); an allocated entry is youngest.
REQ-020 On cntrl_evt_texe_r, a busy unmatured entry SHALL mature next cycle if: CN_GE and the side's table valid and price >= trigger; CN_LE and the side's table valid and price <= trigger; side = bid table for sell-stops, ask table for buy-stops, per cmd field.
REQ-021 Invalid table for the entry's side SHALL inhibit maturity that cycle.
REQ-022 When mtr_vld_r == 0 or mtr_accept == 1, the oldest matured entry SHALL load into mtr_r, mtr_vld_r SHALL become 1 next cycle, and that entry SHALL be freed in the same edge.
REQ-023 If no matured entry exists under REQ-022's condition, mtr_vld_r SHALL become 0; mtr_r SHALL hold while mtr_vld_r & ~mtr_accept.
REQ-024 Latency: evt at cycle t with condition met, empty output -> mtr_vld_r high at t+2.
REQ-025 occ_r SHALL update each cycle by +1 per accepted alloc and -1 per freed entry; simultaneous alloc and free leave it unchanged.
REQ-026 cancel_vld SHALL free the busy entry whose uid matches (matured or not) and pulse cancel_hit_r next cycle; no match -> no pulse, no state change.
REQ-027 Cancel and output load of the same entry in one cycle: load SHALL win, cancel_hit_r stays 0; an entry already in mtr_r SHALL NOT be cancelled.
REQ-028 Two entries with equal uid are illegal input; behaviour undefined (assertion required).

Reset
REQ-029 On rst low: all entries free, age matrix cleared, mtr_vld_r=0, mtr_r=0, occ_r=0, full_r=0, cancel_hit_r=0, alloc_rdy=1.
REQ-030 Reset mid-operation SHALL discard all entries and any pending matured command without emitting it.

Configuration
REQ-031 Macro OB_CN_QUEUE_CANCEL_EN defined: cancel ports and REQ-026/027 logic present.
REQ-032 Macro undefined: cancel_vld/cancel_uid/cancel_hit_r ports absent; entries free only via REQ-022.

Structure
REQ-033 cn_cond_t (CN_GE, CN_LE), uid_t, cmd_t condition fields and table_t SHALL reside in ob_pkg.
REQ-034 Per-entry state (busy, matured, cmd, compare) SHALL be sub-module ob_cn_queue_entry, instantiated N times; age matrix and selection stay in ob_cn_queue.

Verification
REQ-035 Fill: 8 allocs, no evt -> occ_r=8, full_r=1, alloc_rdy=0; 9th offered alloc not accepted.
REQ-036 Maturity: CN_GE trigger 100, ask=101 valid, evt at t -> mtr_vld_r=1 at t+2, mtr_r.uid matches, occ_r decrements.
REQ-037 Ordering: uids 5,3,9 allocated in that order, all mature on one evt, mtr_accept held 1 -> outputs 5,3,9 on consecutive cycles.
REQ-038 Backpressure: mtr_accept=0 for 4 cycles -> mtr_r stable, second matured entry stays busy, occ_r unchanged.
REQ-039 Cancel race (CANCEL_EN): cancel uid 7 same cycle as uid 7 loads output -> uid 7 emitted, cancel_hit_r=0; cancel uid 4 unmatured -> cancel_hit_r pulse, occ_r-1.
REQ-040 Reset: assert rst low with mtr_vld_r=1 and occ_r=5 -> all outputs per REQ-029 immediately, no emission after release.

Source files
------------

// File: rtl/ob_cn_queue_pkg.sv
// ---------------------------------------------------------------------------
// ob_pkg : shared types for the conditional (stop) order queue.
//   uid_t     - command unique id
//   price_t   - price / trigger value
//   cn_cond_t - trigger comparison (CN_GE : price >= trigger, CN_LE : price <= trigger)
//   side_t    - SIDE_BUY watches the best ask, SIDE_SELL watches the best bid
//   cmd_t     - conditional command held by one queue entry
//   table_t   - best-of-book snapshot (price, quantity)
//   cn_met()  - trigger comparison helper
// ---------------------------------------------------------------------------
package ob_pkg;

  localparam int UID_W     = 8;
  localparam int PRICE_W   = 16;
  localparam int QTY_W     = 16;
  localparam int PAYLOAD_W = 16;

  typedef logic [UID_W-1:0]   uid_t;
  typedef logic [PRICE_W-1:0] price_t;

  typedef enum logic {
    CN_GE = 1'b0,
    CN_LE = 1'b1
  } cn_cond_t;

  typedef enum logic {
    SIDE_BUY  = 1'b0,
    SIDE_SELL = 1'b1
  } side_t;

  typedef struct packed {
    uid_t                 uid;
    cn_cond_t             cn_cond;
    side_t                side;
    price_t               trigger;
    logic [PAYLOAD_W-1:0] payload;
  } cmd_t;

  typedef struct packed {
    price_t             price;
    logic [QTY_W-1:0]   qty;
  } table_t;

  function automatic logic cn_met(cn_cond_t cond, price_t price, price_t trigger);
    return (cond == CN_GE) ? (price >= trigger) : (price <= trigger);
  endfunction

endpackage

// File: rtl/ob_cn_queue_if.sv
// ---------------------------------------------------------------------------
// ob_cn_queue_if : bundle of all non-clock/reset signals of ob_cn_queue.
//   alloc_vld/alloc_cmd/alloc_rdy        - command allocation handshake
//   cntrl_evt_texe_r                     - trade-execution event (evaluate triggers)
//   lm_bid_table_vld_r/lm_bid_table_r    - best bid snapshot
//   lm_ask_table_vld_r/lm_ask_table_r    - best ask snapshot
//   mtr_vld_r/mtr_r/mtr_accept           - matured command output
//   cancel_vld/cancel_uid/cancel_hit_r   - cancel path (only with OB_CN_QUEUE_CANCEL_EN)
//   occ_r/full_r                         - occupancy status
// Modports: master = producer/consumer side, slave = queue side.
// Optional feature macro: OB_CN_QUEUE_CANCEL_EN.
// ---------------------------------------------------------------------------
interface ob_cn_queue_if #(
  parameter int N     = 8,
  parameter int W_OCC = $clog2(N + 1)
);
  import ob_pkg::*;

  logic             alloc_vld;
  cmd_t             alloc_cmd;
  logic             alloc_rdy;
  logic             cntrl_evt_texe_r;
  logic             lm_bid_table_vld_r;
  table_t           lm_bid_table_r;
  logic             lm_ask_table_vld_r;
  table_t           lm_ask_table_r;
  logic             mtr_vld_r;
  cmd_t             mtr_r;
  logic             mtr_accept;
`ifdef OB_CN_QUEUE_CANCEL_EN
  logic             cancel_vld;
  uid_t             cancel_uid;
  logic             cancel_hit_r;
`endif
  logic [W_OCC-1:0] occ_r;
  logic             full_r;

`ifdef OB_CN_QUEUE_CANCEL_EN
  modport master (
    output alloc_vld, alloc_cmd, cntrl_evt_texe_r,
    output lm_bid_table_vld_r, lm_bid_table_r, lm_ask_table_vld_r, lm_ask_table_r,
    output mtr_accept, cancel_vld, cancel_uid,
    input  alloc_rdy, mtr_vld_r, mtr_r, cancel_hit_r, occ_r, full_r
  );
  modport slave (
    input  alloc_vld, alloc_cmd, cntrl_evt_texe_r,
    input  lm_bid_table_vld_r, lm_bid_table_r, lm_ask_table_vld_r, lm_ask_table_r,
    input  mtr_accept, cancel_vld, cancel_uid,
    output alloc_rdy, mtr_vld_r, mtr_r, cancel_hit_r, occ_r, full_r
  );
`else
  modport master (
    output alloc_vld, alloc_cmd, cntrl_evt_texe_r,
    output lm_bid_table_vld_r, lm_bid_table_r, lm_ask_table_vld_r, lm_ask_table_r,
    output mtr_accept,
    input  alloc_rdy, mtr_vld_r, mtr_r, occ_r, full_r
  );
  modport slave (
    input  alloc_vld, alloc_cmd, cntrl_evt_texe_r,
    input  lm_bid_table_vld_r, lm_bid_table_r, lm_ask_table_vld_r, lm_ask_table_r,
    input  mtr_accept,
    output alloc_rdy, mtr_vld_r, mtr_r, occ_r, full_r
  );
`endif

endinterface

// File: rtl/ob_cn_queue_entry.sv
// ---------------------------------------------------------------------------
// ob_cn_queue_entry : one slot of the conditional queue.
// Holds busy / matured flags and the command, and evaluates the trigger
// against the relevant side of the book on each trade-execution event.
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   i_alloc, i_cmd           - load a new command (slot must be free)
//   i_free                   - release the slot (output load or cancel)
//   i_evt                    - trade-execution event
//   i_bid_vld/i_bid_price    - best bid (used by sell-side commands)
//   i_ask_vld/i_ask_price    - best ask (used by buy-side commands)
//   i_cancel_vld/i_cancel_uid/o_cancel_match - uid compare for cancel
//                              (only with OB_CN_QUEUE_CANCEL_EN)
//   o_busy, o_matured, o_cmd - slot state
// ---------------------------------------------------------------------------
module ob_cn_queue_entry
  import ob_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_alloc,
  input  cmd_t   i_cmd,
  input  logic   i_free,
  input  logic   i_evt,
  input  logic   i_bid_vld,
  input  price_t i_bid_price,
  input  logic   i_ask_vld,
  input  price_t i_ask_price,
`ifdef OB_CN_QUEUE_CANCEL_EN
  input  logic   i_cancel_vld,
  input  uid_t   i_cancel_uid,
  output logic   o_cancel_match,
`endif
  output logic   o_busy,
  output logic   o_matured,
  output cmd_t   o_cmd
);

  logic   r_busy;
  logic   r_matured;
  cmd_t   r_cmd;

  logic   w_tbl_vld;
  price_t w_tbl_price;
  logic   w_hit;

  // Sell-stops watch the bid, buy-stops watch the ask.
  always_comb begin
    w_tbl_vld   = i_ask_vld;
    w_tbl_price = i_ask_price;
    if (r_cmd.side == SIDE_SELL) begin
      w_tbl_vld   = i_bid_vld;
      w_tbl_price = i_bid_price;
    end
    w_hit = i_evt & r_busy & ~r_matured & w_tbl_vld &
            cn_met(r_cmd.cn_cond, w_tbl_price, r_cmd.trigger);
  end

  // Free has priority; alloc only targets a free slot so the two never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy    <= 1'b0;
      r_matured <= 1'b0;
      r_cmd     <= '0;
    end else if (i_free) begin
      r_busy    <= 1'b0;
      r_matured <= 1'b0;
    end else if (i_alloc) begin
      r_busy    <= 1'b1;
      r_matured <= 1'b0;
      r_cmd     <= i_cmd;
    end else if (w_hit) begin
      r_matured <= 1'b1;
    end
  end

`ifdef OB_CN_QUEUE_CANCEL_EN
  assign o_cancel_match = i_cancel_vld & r_busy & (r_cmd.uid == i_cancel_uid);
`endif

  assign o_busy    = r_busy;
  assign o_matured = r_matured;
  assign o_cmd     = r_cmd;

endmodule

// File: rtl/ob_cn_queue.sv
// ---------------------------------------------------------------------------
// ob_cn_queue : queue of N conditional (stop) commands.
// Commands are parked in the lowest free slot, mature when their trigger
// condition holds on a trade-execution event, and leave oldest-first through
// a registered output stage. An N x N age matrix tracks relative order.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   bus  - ob_cn_queue_if.slave (alloc, book tables, matured output,
//          optional cancel, occupancy)
// Optional feature macro: OB_CN_QUEUE_CANCEL_EN enables cancel-by-uid.
// ---------------------------------------------------------------------------
module ob_cn_queue
  import ob_pkg::*;
#(
  parameter int N     = 8,
  parameter int W_OCC = $clog2(N + 1)
)(
  input  logic            clk,
  input  logic            rst,
  ob_cn_queue_if.slave    bus
);

  localparam logic [N-1:0] LP_ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0]     w_busy;
  logic [N-1:0]     w_matured;
  cmd_t             w_cmd [N];
  logic [N-1:0]     w_free;
  logic [N-1:0]     w_lowest_free;
  logic [N-1:0]     w_alloc_oh;
  logic [N-1:0]     w_sel_oh;
  logic [N-1:0]     w_load_oh;
  logic [N-1:0]     w_free_oh;
  logic             w_alloc_fire;
  logic             w_out_ready;
  logic             w_load;
  logic             w_cancel_any;
  logic [$bits(cmd_t)-1:0] w_sel_bits;
  logic [W_OCC-1:0] w_occ_next;
  logic             w_unused;

  // r_age[i][j] == 1 : entry i is older than entry j.
  logic [N-1:0]     r_age [N];
  logic             r_mtr_vld;
  cmd_t             r_mtr;
  logic [W_OCC-1:0] r_occ;
  logic             r_full;

  // Quantity fields of the book tables are not needed for triggering.
  assign w_unused = ^{bus.lm_bid_table_r.qty, bus.lm_ask_table_r.qty};

  // -------------------------------------------------------------------------
  // Allocation: lowest free slot (x & -x). Only slots free at the start of
  // the cycle count, so a slot released this cycle is reused next cycle.
  // -------------------------------------------------------------------------
  assign w_alloc_fire  = bus.alloc_vld & ~r_full;
  assign w_free        = ~w_busy;
  assign w_lowest_free = w_free & (~w_free + LP_ONE);
  assign w_alloc_oh    = w_lowest_free & {N{w_alloc_fire}};

  // -------------------------------------------------------------------------
  // Entries
  // -------------------------------------------------------------------------
`ifdef OB_CN_QUEUE_CANCEL_EN
  logic [N-1:0] w_cancel_match;
  logic [N-1:0] w_cancel_oh;
  logic         r_cancel_hit;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_entry
      ob_cn_queue_entry u_entry (
        .clk            (clk),
        .rst            (rst),
        .i_alloc        (w_alloc_oh[gi]),
        .i_cmd          (bus.alloc_cmd),
        .i_free         (w_free_oh[gi]),
        .i_evt          (bus.cntrl_evt_texe_r),
        .i_bid_vld      (bus.lm_bid_table_vld_r),
        .i_bid_price    (bus.lm_bid_table_r.price),
        .i_ask_vld      (bus.lm_ask_table_vld_r),
        .i_ask_price    (bus.lm_ask_table_r.price),
`ifdef OB_CN_QUEUE_CANCEL_EN
        .i_cancel_vld   (bus.cancel_vld),
        .i_cancel_uid   (bus.cancel_uid),
        .o_cancel_match (w_cancel_match[gi]),
`endif
        .o_busy         (w_busy[gi]),
        .o_matured      (w_matured[gi]),
        .o_cmd          (w_cmd[gi])
      );
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Age matrix: a newcomer is older than nobody and everybody is older than
  // it. Stale bits of free slots are harmless because selection masks them.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) r_age[i] <= '0;
    end else if (w_alloc_fire) begin
      for (int i = 0; i < N; i++) begin
        if (w_alloc_oh[i]) r_age[i] <= '0;
        else               r_age[i] <= r_age[i] | w_alloc_oh;
      end
    end
  end

  // Oldest matured entry: matured and older than every other matured entry.
  generate
    for (gi = 0; gi < N; gi++) begin : g_sel
      assign w_sel_oh[gi] = w_matured[gi] &
                            ~|(w_matured & ~r_age[gi] & ~(LP_ONE << gi));
    end
  endgenerate

  always_comb begin
    w_sel_bits = '0;
    for (int i = 0; i < N; i++) begin
      if (w_sel_oh[i]) w_sel_bits = w_sel_bits | w_cmd[i];
    end
  end

  // -------------------------------------------------------------------------
  // Output stage: refill whenever empty or being consumed.
  // -------------------------------------------------------------------------
  assign w_out_ready = ~r_mtr_vld | bus.mtr_accept;
  assign w_load      = w_out_ready & (|w_matured);
  assign w_load_oh   = w_sel_oh & {N{w_out_ready}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mtr_vld <= 1'b0;
      r_mtr     <= '0;
    end else if (w_out_ready) begin
      r_mtr_vld <= |w_matured;
      if (|w_matured) r_mtr <= cmd_t'(w_sel_bits);
    end
  end

  // -------------------------------------------------------------------------
  // Cancel: an entry being loaded this cycle is owned by the output stage.
  // -------------------------------------------------------------------------
`ifdef OB_CN_QUEUE_CANCEL_EN
  assign w_cancel_oh  = w_cancel_match & ~w_load_oh;
  assign w_cancel_any = |w_cancel_oh;
  assign w_free_oh    = w_load_oh | w_cancel_oh;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cancel_hit <= 1'b0;
    else      r_cancel_hit <= w_cancel_any;
  end

  assign bus.cancel_hit_r = r_cancel_hit;
`else
  assign w_cancel_any = 1'b0;
  assign w_free_oh    = w_load_oh;
`endif

  // -------------------------------------------------------------------------
  // Occupancy
  // -------------------------------------------------------------------------
  always_comb begin
    w_occ_next = r_occ;
    if (w_alloc_fire) w_occ_next = w_occ_next + W_OCC'(1);
    if (w_load)       w_occ_next = w_occ_next - W_OCC'(1);
    if (w_cancel_any) w_occ_next = w_occ_next - W_OCC'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ  <= '0;
      r_full <= 1'b0;
    end else begin
      r_occ  <= w_occ_next;
      r_full <= (w_occ_next == W_OCC'(N));
    end
  end

  assign bus.alloc_rdy = ~r_full;
  assign bus.mtr_vld_r = r_mtr_vld;
  assign bus.mtr_r     = r_mtr;
  assign bus.occ_r     = r_occ;
  assign bus.full_r    = r_full;

  // -------------------------------------------------------------------------
  // Duplicate uids among live entries are not supported.
  // -------------------------------------------------------------------------
`ifndef SYNTHESIS
  logic [N-1:0] w_uid_dup;
  generate
    for (gi = 0; gi < N; gi++) begin : g_dup
      assign w_uid_dup[gi] = w_busy[gi] & ~w_free_oh[gi] &
                             (w_cmd[gi].uid == bus.alloc_cmd.uid);
    end
  endgenerate

  a_uid_unique: assert property (@(posedge clk) disable iff (!rst)
    w_alloc_fire |-> (w_uid_dup == '0))
    else $error("ob_cn_queue: duplicate uid allocated");
`endif

endmodule

// File: tb/tb_ob_cn_queue.sv
`timescale 1ns/1ps
module tb_ob_cn_queue;
  import ob_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ob_cn_queue_if #(.N(N)) bus ();

  ob_cn_queue #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  function automatic cmd_t mk_cmd(int uid, cn_cond_t c, side_t s, int trig);
    cmd_t m;
    m.uid     = uid_t'(uid);
    m.cn_cond = c;
    m.side    = s;
    m.trigger = price_t'(trig);
    m.payload = PAYLOAD_W'(uid * 3);
    return m;
  endfunction

  task automatic alloc(int uid, cn_cond_t c, side_t s, int trig);
    bus.alloc_vld = 1'b1;
    bus.alloc_cmd = mk_cmd(uid, c, s, trig);
    tick();
    bus.alloc_vld = 1'b0;
  endtask

  task automatic evt();
    bus.cntrl_evt_texe_r = 1'b1;
    tick();
    bus.cntrl_evt_texe_r = 1'b0;
  endtask

  task automatic set_bid(logic v, int p);
    bus.lm_bid_table_vld_r      = v;
    bus.lm_bid_table_r.price    = price_t'(p);
  endtask

  task automatic set_ask(logic v, int p);
    bus.lm_ask_table_vld_r      = v;
    bus.lm_ask_table_r.price    = price_t'(p);
  endtask

  // Scoreboard monitor: one compare per emitted (valid & accepted) command.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst && bus.mtr_vld_r && bus.mtr_accept) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_emit: got uid %0d, expected no emission", bus.mtr_r.uid);
        end else begin
          int e;
          e = exp_q.pop_front();
          $display("emit uid %0d payload %0d", bus.mtr_r.uid, bus.mtr_r.payload);
          chk("emit_uid", int'(bus.mtr_r.uid), e);
          chk("emit_payload", int'(bus.mtr_r.payload), (e * 3) & 16'hFFFF);
        end
      end
    end
  endtask

  initial begin
    bus.alloc_vld         = 1'b0;
    bus.alloc_cmd         = '0;
    bus.cntrl_evt_texe_r  = 1'b0;
    bus.lm_bid_table_r    = '0;
    bus.lm_ask_table_r    = '0;
    set_bid(1'b1, 50);
    set_ask(1'b1, 60);
    bus.mtr_accept        = 1'b1;
`ifdef OB_CN_QUEUE_CANCEL_EN
    bus.cancel_vld        = 1'b0;
    bus.cancel_uid        = '0;
`endif
    fork
      monitor();
    join_none

    // ---------------- reset state ----------------
    #12;
    chk("rst_mtr_vld",   bus.mtr_vld_r, 0);
    chk("rst_occ",       bus.occ_r,     0);
    chk("rst_full",      bus.full_r,    0);
    chk("rst_alloc_rdy", bus.alloc_rdy, 1);
`ifdef OB_CN_QUEUE_CANCEL_EN
    chk("rst_cancel_hit", bus.cancel_hit_r, 0);
`endif
    tick();
    rst = 1'b1;
    tick();

    // ---------------- fill ----------------
    for (int i = 0; i < 8; i++) alloc(10 + i, CN_GE, SIDE_BUY, 1000);
    chk("fill_occ",       bus.occ_r,     8);
    chk("fill_full",      bus.full_r,    1);
    chk("fill_alloc_rdy", bus.alloc_rdy, 0);
    alloc(18, CN_GE, SIDE_BUY, 1000);
    chk("fill_9th_occ",   bus.occ_r,     8);
    set_ask(1'b1, 1000);
    for (int i = 0; i < 8; i++) exp_q.push_back(10 + i);
    evt();
    repeat (10) tick();
    chk("drain_occ", bus.occ_r,     0);
    chk("drain_vld", bus.mtr_vld_r, 0);
    set_ask(1'b1, 60);

    // ---------------- maturity latency ----------------
    alloc(20, CN_GE, SIDE_BUY, 100);
    set_ask(1'b1, 99);
    evt();
    tick();
    chk("mat_below_vld", bus.mtr_vld_r, 0);
    chk("mat_below_occ", bus.occ_r,     1);
    set_ask(1'b1, 101);
    exp_q.push_back(20);
    evt();
    chk("mat_t1_vld", bus.mtr_vld_r, 0);
    tick();
    chk("mat_t2_vld", bus.mtr_vld_r, 1);
    chk("mat_t2_uid", int'(bus.mtr_r.uid), 20);
    chk("mat_t2_occ", bus.occ_r, 0);
    tick();
    chk("mat_t3_vld", bus.mtr_vld_r, 0);

    // ---------------- invalid table / CN_LE boundary ----------------
    alloc(21, CN_LE, SIDE_SELL, 50);
    set_bid(1'b0, 40);
    set_ask(1'b1, 10);
    evt();
    tick();
    chk("inv_tbl_vld", bus.mtr_vld_r, 0);
    chk("inv_tbl_occ", bus.occ_r,     1);
    set_bid(1'b1, 50);
    exp_q.push_back(21);
    evt();
    tick();
    chk("le_eq_vld", bus.mtr_vld_r, 1);
    chk("le_eq_uid", int'(bus.mtr_r.uid), 21);
    tick();
    set_ask(1'b1, 60);

    // ---------------- age ordering (age order differs from slot order) ----
    alloc(50, CN_LE, SIDE_SELL, 10);
    alloc(51, CN_LE, SIDE_SELL, 10);
    alloc(5,  CN_GE, SIDE_BUY,  200);
    set_bid(1'b1, 5);
    exp_q.push_back(50);
    exp_q.push_back(51);
    evt();
    repeat (4) tick();
    set_bid(1'b1, 50);
    alloc(3, CN_GE, SIDE_BUY, 200);
    alloc(9, CN_GE, SIDE_BUY, 200);
    set_ask(1'b1, 200);
    exp_q.push_back(5);
    exp_q.push_back(3);
    exp_q.push_back(9);
    evt();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("ord_vld%0d", k), bus.mtr_vld_r, 1);
    end
    tick();
    chk("ord_end_vld", bus.mtr_vld_r, 0);
    chk("ord_end_occ", bus.occ_r,     0);
    set_ask(1'b1, 60);

    // ---------------- backpressure ----------------
    bus.mtr_accept = 1'b0;
    alloc(60, CN_GE, SIDE_BUY, 300);
    alloc(61, CN_GE, SIDE_BUY, 300);
    set_ask(1'b1, 300);
    exp_q.push_back(60);
    exp_q.push_back(61);
    evt();
    tick();
    chk("bp_vld", bus.mtr_vld_r, 1);
    chk("bp_occ", bus.occ_r,     1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("bp_hold_uid%0d", k), int'(bus.mtr_r.uid), 60);
      chk($sformatf("bp_hold_occ%0d", k), bus.occ_r, 1);
    end
    bus.mtr_accept = 1'b1;
    tick();
    chk("bp_next_uid", int'(bus.mtr_r.uid), 61);
    chk("bp_next_occ", bus.occ_r, 0);
    tick();
    chk("bp_end_vld", bus.mtr_vld_r, 0);
    set_ask(1'b1, 60);

`ifdef OB_CN_QUEUE_CANCEL_EN
    // ---------------- cancel ----------------
    alloc(4, CN_GE, SIDE_BUY, 900);
    bus.cancel_vld = 1'b1;
    bus.cancel_uid = uid_t'(4);
    tick();
    bus.cancel_vld = 1'b0;
    chk("cancel_hit", bus.cancel_hit_r, 1);
    chk("cancel_occ", bus.occ_r,        0);
    tick();
    chk("cancel_pulse_end", bus.cancel_hit_r, 0);

    alloc(8, CN_GE, SIDE_BUY, 900);
    bus.cancel_vld = 1'b1;
    bus.cancel_uid = uid_t'(99);
    tick();
    chk("cancel_miss_hit", bus.cancel_hit_r, 0);
    chk("cancel_miss_occ", bus.occ_r,        1);
    bus.cancel_uid = uid_t'(8);
    tick();
    bus.cancel_vld = 1'b0;
    chk("cancel_8_hit", bus.cancel_hit_r, 1);

    // cancel racing the output load of the same entry
    bus.mtr_accept = 1'b0;
    alloc(7, CN_GE, SIDE_BUY, 400);
    set_ask(1'b1, 400);
    exp_q.push_back(7);
    evt();
    bus.cancel_vld = 1'b1;
    bus.cancel_uid = uid_t'(7);
    tick();
    chk("race_hit", bus.cancel_hit_r, 0);
    chk("race_vld", bus.mtr_vld_r,    1);
    chk("race_uid", int'(bus.mtr_r.uid), 7);
    chk("race_occ", bus.occ_r,        0);
    tick();
    bus.cancel_vld = 1'b0;
    chk("held_hit", bus.cancel_hit_r, 0);
    chk("held_vld", bus.mtr_vld_r,    1);
    bus.mtr_accept = 1'b1;
    tick();
    tick();
    chk("race_end_vld", bus.mtr_vld_r, 0);
    set_ask(1'b1, 60);
`endif

    // ---------------- reset mid-operation ----------------
    bus.mtr_accept = 1'b0;
    alloc(70, CN_GE, SIDE_BUY, 500);
    for (int i = 71; i <= 75; i++) alloc(i, CN_GE, SIDE_BUY, 900);
    set_ask(1'b1, 500);
    evt();
    tick();
    chk("rm_pre_vld", bus.mtr_vld_r, 1);
    chk("rm_pre_occ", bus.occ_r,     5);
    #2;
    rst = 1'b0;
    #1;
    chk("rm_vld",      bus.mtr_vld_r, 0);
    chk("rm_occ",      bus.occ_r,     0);
    chk("rm_full",     bus.full_r,    0);
    chk("rm_rdy",      bus.alloc_rdy, 1);
    chk("rm_mtr_zero", int'(bus.mtr_r != '0), 0);
    tick();
    rst = 1'b1;
    bus.mtr_accept = 1'b1;
    set_ask(1'b1, 900);
    evt();
    repeat (5) tick();
    chk("rm_after_vld", bus.mtr_vld_r, 0);
    chk("rm_after_occ", bus.occ_r,     0);

    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
